// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer: sweeps a parallel ROM from address 0 to LAST_ADDRESS with
// programmable CE/OE setup and access delays, handing each byte off over valid/ready.
module rom_read_sequencer #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int ACCESS_CYCLES = 4,
    parameter int LAST_ADDRESS  = 511
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    input  logic                     data_ready,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic                     rom_ce_n,
    output logic                     rom_oe_n,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     done
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HANDOFF, DONE} state_t;
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] ACCESS_LAST = 8'(ACCESS_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(LAST_ADDRESS);
    state_t state;
    logic [7:0] count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            address_line <= '0;
            rom_ce_n <= 1'b1;
            rom_oe_n <= 1'b1;
            data_out <= '0;
            data_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    address_line <= '0;
                    rom_ce_n <= 1'b0;
                    busy <= 1'b1;
                    count <= '0;
                    state <= SETUP;
                end
                SETUP: if (count == SETUP_LAST) begin
                    rom_oe_n <= 1'b0;
                    count <= '0;
                    state <= ACCESS;
                end else count <= count + 8'd1;
                // Capture on the final access edge, while OE is still low.
                ACCESS: if (count == ACCESS_LAST) begin
                    data_out <= rom_data;
                    data_valid <= 1'b1;
                    rom_oe_n <= 1'b1;
                    rom_ce_n <= 1'b1;
                    state <= HANDOFF;
                end else count <= count + 8'd1;
                HANDOFF: if (data_ready) begin
                    data_valid <= 1'b0;
                    if (address_line == LAST) begin
                        done <= 1'b1;
                        state <= DONE;
                    end else begin
                        address_line <= address_line + ADDRESS_WIDTH'(1);
                        rom_ce_n <= 1'b0;
                        count <= '0;
                        state <= SETUP;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_read_sequencer.sv
// tb_rom_read_sequencer: directed checks of reset, single-word timing, backpressure,
// ignored start, mid-sweep reset and a full 512-word sweep with random ready.
module tb_rom_read_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // single-word instance (LAST_ADDRESS = 0)
    logic       w_start = 1'b0;
    logic [7:0] w_data = 8'hA5;
    logic       w_ready = 1'b1;
    logic [8:0] w_addr;
    logic       w_ce, w_oe, w_valid, w_busy, w_done;
    logic [7:0] w_dout;

    // default instance (LAST_ADDRESS = 511)
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic       ovr = 1'b0;
    logic [7:0] ovr_val = 8'h00;
    logic [7:0] rom_data;
    logic [8:0] addr;
    logic       ce, oe, valid, busy, done;
    logic [7:0] dout;

    assign rom_data = ovr ? ovr_val : (addr[7:0] ^ 8'h3C);

    rom_read_sequencer #(.LAST_ADDRESS(0)) dut0 (
        .clk(clk), .reset(reset), .start(w_start), .rom_data(w_data), .data_ready(w_ready),
        .address_line(w_addr), .rom_ce_n(w_ce), .rom_oe_n(w_oe), .data_out(w_dout),
        .data_valid(w_valid), .busy(w_busy), .done(w_done)
    );

    rom_read_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .rom_data(rom_data), .data_ready(ready),
        .address_line(addr), .rom_ce_n(ce), .rom_oe_n(oe), .data_out(dout),
        .data_valid(valid), .busy(busy), .done(done)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, next_addr, done_cnt;
        // asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #2;
        check("rst_ce", ce, 1);
        check("rst_oe", oe, 1);
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_w_ce", w_ce, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // single-word timing on the LAST_ADDRESS=0 instance
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        check("sw_addr", w_addr, 0);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            check($sformatf("sw_ce_%0d", k), w_ce, (k <= 5) ? 1'b0 : 1'b1);
            check($sformatf("sw_oe_%0d", k), w_oe, (k >= 2 && k <= 5) ? 1'b0 : 1'b1);
            check($sformatf("sw_valid_%0d", k), w_valid, k == 6);
            check($sformatf("sw_done_%0d", k), w_done, k == 7);
            check($sformatf("sw_busy_%0d", k), w_busy, k <= 7);
            if (k == 6) check("sw_dout", w_dout, 8'hA5);
        end

        // backpressure on word 0 of the default instance
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        check("bp_valid", valid, 1);
        check("bp_dout", dout, 8'h3C);
        for (int k = 7; k <= 11; k++) begin
            ovr = 1'b1;
            ovr_val = 8'(k * 17);
            tick();
            check($sformatf("bp_hold_dout_%0d", k), dout, 8'h3C);
            check($sformatf("bp_hold_valid_%0d", k), valid, 1);
            check($sformatf("bp_hold_addr_%0d", k), addr, 0);
            check($sformatf("bp_hold_ce_%0d", k), ce, 1);
        end
        ovr = 1'b0;
        ready = 1'b1;
        tick();
        check("bp_rel_valid", valid, 0);
        check("bp_rel_addr", addr, 1);
        check("bp_rel_ce", ce, 0);

        // word 1 with start toggling: timing must match a plain word
        for (int k = 1; k <= 7; k++) begin
            start = k[0];
            tick();
            check($sformatf("ign_ce_%0d", k), ce, (k <= 5 || k == 7) ? 1'b0 : 1'b1);
            check($sformatf("ign_oe_%0d", k), oe, (k >= 2 && k <= 5) ? 1'b0 : 1'b1);
            check($sformatf("ign_valid_%0d", k), valid, k == 6);
            check($sformatf("ign_addr_%0d", k), addr, (k < 7) ? 1 : 2);
            if (k == 6) check("ign_dout", dout, 8'h3D);
        end
        start = 1'b0;

        // run to ACCESS at address 37, then reset asynchronously
        n = 0;
        while (!(addr == 9'd37 && oe == 1'b0) && n < 1000) begin
            tick();
            n++;
        end
        check("mid_reached", n < 1000, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_ce", ce, 1);
        check("mid_oe", oe, 1);
        check("mid_addr", addr, 0);
        check("mid_busy", busy, 0);
        check("mid_valid", valid, 0);
        check("mid_done", done, 0);
        tick();
        #2 reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check("mid_no_done", done_cnt, 0);
        check("mid_idle_busy", busy, 0);

        // restart, then full sweep with random ready
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_addr", addr, 0);
        check("rs_ce", ce, 0);
        check("rs_busy", busy, 1);
        next_addr = 0;
        done_cnt = 0;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            ready = 1'($urandom_range(0, 1));
            if (valid && ready) begin
                check($sformatf("sweep_addr_%0d", next_addr), addr, next_addr);
                check($sformatf("sweep_data_%0d", next_addr), dout, 8'(next_addr) ^ 8'h3C);
                next_addr++;
            end
            tick();
            if (done) done_cnt++;
            n++;
        end
        check("sweep_in_time", n < 20000, 1);
        check("sweep_count", next_addr, 512);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check("sweep_one_done", done_cnt, 1);
        check("sweep_addr_hold", addr, 511);
        check("sweep_busy_end", busy, 0);
        check("sweep_ce_end", ce, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rom_read_sequencer.md
# rom_read_sequencer

Sequences a full read of a parallel ROM chip. It walks the 9-bit address space from 0 to LAST_ADDRESS and drives the chip-enable and output-enable strobes with programmable setup and access delays. Each captured byte is handed downstream over a valid/ready handshake. Its `address_line` output is the address source for the seven-segment address display stage, which shows the word currently being read.

## Interface
- `ADDRESS_WIDTH`, 9: address bus width; must match the display stage input.
- `DATA_WIDTH`, 8: ROM data width.
- `SETUP_CYCLES`, 2: cycles with address and `rom_ce_n` asserted before `rom_oe_n` asserts; legal range 1..255.
- `ACCESS_CYCLES`, 4: cycles `rom_oe_n` is held low before data is captured; legal range 1..255.
- `LAST_ADDRESS`, 511: final address read in a sweep.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE, begins a sweep.
- `rom_data`  in  DATA_WIDTH  ROM data bus.
- `data_ready`  in  1  downstream accepts `data_out` when high at a rising edge while `data_valid` is high.
- `address_line`  out  ADDRESS_WIDTH  current ROM address; also feeds the display stage.
- `rom_ce_n`  out  1  ROM chip enable, active-low.
- `rom_oe_n`  out  1  ROM output enable, active-low.
- `data_out`  out  DATA_WIDTH  captured byte.
- `data_valid`  out  1  `data_out` is valid.
- `busy`  out  1  a sweep is in progress.
- `done`  out  1  one-cycle pulse at the end of a sweep.

## Operation
- Reset values (asserted immediately, independent of `clk`): state IDLE, `address_line`=0, `rom_ce_n`=1, `rom_oe_n`=1, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0, delay counter=0.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, HANDOFF, DONE.
- IDLE: strobes deasserted.
  - `start`=1 at an edge: `address_line`←0, `rom_ce_n`←0, `busy`←1, counter←0, go to SETUP.
- SETUP: lasts SETUP_CYCLES cycles; `rom_ce_n`=0, `rom_oe_n`=1.
  - On the last cycle's edge: `rom_oe_n`←0, counter←0, go to ACCESS.
- ACCESS: lasts ACCESS_CYCLES cycles; `rom_ce_n`=0, `rom_oe_n`=0.
  - On the last cycle's edge: `data_out`←`rom_data`, `data_valid`←1, `rom_oe_n`←1, `rom_ce_n`←1, go to HANDOFF.
- HANDOFF: `data_out` and `data_valid` are held stable until `data_ready`=1 at an edge. On that edge, `data_valid`←0, and then:
  - if `address_line`==LAST_ADDRESS: go to DONE, `done`←1;
  - otherwise: `address_line`←`address_line`+1, `rom_ce_n`←0, counter←0, go to SETUP.
- DONE: lasts one cycle; `done`=1.
  - Next edge: `done`←0, `busy`←0, go to IDLE.
  - `address_line` keeps LAST_ADDRESS until the next `start`.
- `start` is ignored outside IDLE.
- `start` held high continuously re-launches a sweep on the first edge in IDLE after DONE.
- Address arithmetic is unsigned ADDRESS_WIDTH.
  - The increment never wraps inside a sweep, because the sweep terminates at LAST_ADDRESS.
  - LAST_ADDRESS=2^ADDRESS_WIDTH−1 is legal.
- `address_line` changes only on the IDLE→SETUP and HANDOFF→SETUP edges, so the display stage always sees a stable value for at least SETUP_CYCLES+ACCESS_CYCLES+1 cycles.
- Reset mid-sweep aborts immediately: strobes deassert, any pending `data_valid` is dropped, and no `done` pulse is produced.

## Timing
- Edge N samples `start`=1. `rom_ce_n` falls and `address_line` becomes 0 after edge N.
- `rom_oe_n` falls after edge N+SETUP_CYCLES.
- `data_valid` rises after edge N+SETUP_CYCLES+ACCESS_CYCLES. With defaults this is after edge N+6.
- `rom_data` is sampled at edge N+SETUP_CYCLES+ACCESS_CYCLES, i.e. while `rom_oe_n` is still low.
- With `data_ready` tied high:
  - each word occupies SETUP_CYCLES+ACCESS_CYCLES+1 cycles (7 by default);
  - a full default sweep takes 512×7 cycles, then 1 DONE cycle;
  - `busy` is high for 3585 cycles.
- Each cycle of `data_ready`=0 in HANDOFF extends the word by exactly one cycle.
- `rom_ce_n` is high for exactly the HANDOFF cycles between words.

## Test plan
- Reset check: assert `reset`=0 asynchronously between clock edges. All outputs must take their reset values before the next edge: `rom_ce_n`=`rom_oe_n`=1, `address_line`=0, `busy`=0.
- Single-word timing: use LAST_ADDRESS=0, `rom_data`=8'hA5, `data_ready`=1, pulse `start` at edge N.
  - `rom_ce_n` is low over edges N+1..N+6 and `rom_oe_n` is low over edges N+3..N+6.
  - `data_valid`=1 with `data_out`=8'hA5 for one cycle after edge N+6.
  - `done` pulses after edge N+7; `busy` falls after edge N+8.
- Backpressure: hold `data_ready`=0 for 5 cycles while `data_valid`=1, and change `rom_data` during the stall. `data_out` must be unchanged, `address_line` must not advance, and the word must take 12 cycles.
- Full sweep: ROM model returns `address[7:0]`^8'h3C, `data_ready` random. All 512 bytes must arrive in address order with correct values, followed by exactly one `done` pulse, and `address_line` must stay at 511 afterwards.
- `start` ignored: toggle `start` during SETUP, ACCESS and HANDOFF. The sequence and cycle counts must be identical to the run with `start` held low.
- Mid-sweep reset: apply reset during ACCESS at address 37. Outputs must return to reset values, with no `done` pulse. A following `start` must restart the sweep at address 0.
